// File: rtl/md_pkg.sv
// md_pkg: shared opcode encodings, sequencer state and counter width for the
// multiply/divide sequencer. Optional feature macro: MD_MADD_EN (enables the
// MADD/MADDU/MSUB/MSUBU accumulate opcodes).
package md_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MTHI  = 4'd4,
    MD_MTLO  = 4'd5,
    MD_MADD  = 4'd6,
    MD_MADDU = 4'd7,
    MD_MSUB  = 4'd8,
    MD_MSUBU = 4'd9
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Ops that take the multiplier latency and hold busy.
  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) ||
             (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  // Ops that take the divider latency and hold busy.
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_multicycle(input logic [3:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/md_seq_if.sv
// md_seq_if: E-stage request and HI/LO result bundle for the md sequencer.
// The pipeline side uses the master modport, the sequencer the slave modport.
interface md_seq_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic        busy_or_start;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, flush,
    input  busy, busy_or_start, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush,
    output busy, busy_or_start, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational multiply/divide/accumulate datapath. Produces the
// 64-bit {hi,lo} value an op will commit, plus a divide-by-zero flag.
// Accumulate opcodes are only decoded when MD_MADD_EN is defined.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        div0
);

  // Two's complement negate when the condition is set.
  function automatic logic [31:0] neg_if(input logic c, input logic [31:0] v);
    return c ? (32'd0 - v) : v;
  endfunction

  logic signed [63:0] sa, sb, sprod;
  logic        [63:0] uprod;
  logic        [31:0] ua, ub, b_safe, ub_safe;
  logic        [31:0] uq, ur, sq, sr, dq, dr;

  // Products, then sign-magnitude division so INT_MIN / -1 wraps cleanly.
  always_comb begin
    sa      = {{32{a[31]}}, a};
    sb      = {{32{b[31]}}, b};
    sprod   = sa * sb;
    uprod   = {32'd0, a} * {32'd0, b};
    div0    = (b == 32'd0);
    b_safe  = div0 ? 32'd1 : b;
    ua      = neg_if(a[31], a);
    ub      = neg_if(b[31], b);
    ub_safe = div0 ? 32'd1 : ub;
    uq      = ua / ub_safe;
    ur      = ua % ub_safe;
    sq      = neg_if(a[31] ^ b[31], uq);
    sr      = neg_if(a[31], ur);
    dq      = a / b_safe;
    dr      = a % b_safe;
  end

  // Select the committed value by opcode; unknown ops leave HI/LO as is.
  always_comb begin
    res = {hi, lo};
    unique case (op)
      MD_MULT:  res = sprod;
      MD_MULTU: res = uprod;
      MD_DIV:   res = {sr, sq};
      MD_DIVU:  res = {dr, dq};
`ifdef MD_MADD_EN
      MD_MADD:  res = {hi, lo} + sprod;
      MD_MADDU: res = {hi, lo} + uprod;
      MD_MSUB:  res = {hi, lo} - sprod;
      MD_MSUBU: res = {hi, lo} - uprod;
`endif
      default:  res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_seq.sv
// md_seq: sequencer for the shared multiply/divide unit in the E stage.
// Accepts one HI/LO op per start, holds busy for MUL_CYCLES/DIV_CYCLES, then
// commits into HI/LO. busy_or_start feeds the mult/div interlock. A start in
// the same cycle as flush is dropped. Optional macro: MD_MADD_EN.
module md_seq
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_seq_if.slave    bus
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             div0_q, div0_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]      arith_res;
  logic             arith_div0;
  logic             accept;
  logic             mc_op;

  md_arith u_arith (
    .op   (bus.op),
    .a    (bus.rs_val),
    .b    (bus.rt_val),
    .hi   (hi_q),
    .lo   (lo_q),
    .res  (arith_res),
    .div0 (arith_div0)
  );

  assign mc_op  = is_multicycle(bus.op);
  assign accept = bus.start && !bus.flush && (state_q == IDLE);

  // Next state: accept/launch in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (mc_op) begin
            state_d = RUN;
            cnt_d   = is_div_op(bus.op) ? DIV_CNT : MUL_CNT;
            pend_d  = arith_res;
            div0_d  = is_div_op(bus.op) && arith_div0;
          end else if (bus.op == MD_MTHI) begin
            hi_d = bus.rs_val;
          end else if (bus.op == MD_MTLO) begin
            lo_d = bus.rs_val;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (!div0_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy          = (state_q == RUN);
  assign bus.busy_or_start = (state_q == RUN) || (bus.start && !bus.flush && mc_op);
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;

  // The stall unit must never present a start while an op is in flight.
  a_no_start_in_run : assert property (
    @(posedge clk) disable iff (!reset) (state_q == RUN) |-> !bus.start
  );

endmodule
